// File: rtl/digit_entry.sv
// Three-digit keypad entry register with clear/enter handling and registered pulse outputs.
// Optional inactivity timeout is compiled in when DIGIT_ENTRY_TIMEOUT_EN is defined.
module digit_entry #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [11:0] code,
  output logic        code_valid,
  output logic [1:0]  digit_cnt,
  output logic        err,
  output logic        timeout
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ENTRY,
    S_FULL,
    S_SUBMIT
  } state_e;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("digit_entry: TIMEOUT_CYCLES out of range 2..65535");
  end

  state_e      state_q, state_d;
  logic [11:0] code_q, code_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        code_valid_q, code_valid_d;
  logic        err_q, err_d;
  logic        is_digit;

  assign is_digit = (key_code <= 4'd9);

`ifdef DIGIT_ENTRY_TIMEOUT_EN
  localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] idle_q, idle_d;
  logic        timeout_q, timeout_d;
  logic        expire;

  // Only a fully idle cycle can expire the entry; a key on that edge wins.
  assign expire = ((state_q == S_ENTRY) || (state_q == S_FULL)) &&
                  !key_valid && (idle_q == IDLE_LAST);
`endif

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    cnt_d        = cnt_q;
    code_valid_d = 1'b0;
    err_d        = 1'b0;

    if (state_q == S_SUBMIT) begin
      state_d = S_EMPTY;
      code_d  = '0;
      cnt_d   = '0;
      err_d   = key_valid;
    end else if (key_valid) begin
      if (is_digit) begin
        if (state_q == S_FULL) begin
          err_d = 1'b1;
        end else begin
          code_d  = {code_q[7:0], key_code};
          cnt_d   = cnt_q + 2'd1;
          state_d = (cnt_q == 2'd2) ? S_FULL : S_ENTRY;
        end
      end else if (key_code == KEY_CLEAR) begin
        state_d = S_EMPTY;
        code_d  = '0;
        cnt_d   = '0;
      end else if (key_code == KEY_ENTER) begin
        if (state_q == S_FULL) begin
          state_d      = S_SUBMIT;
          code_valid_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        err_d = 1'b1;
      end
    end

`ifdef DIGIT_ENTRY_TIMEOUT_EN
    timeout_d = 1'b0;
    if (expire) begin
      state_d   = S_EMPTY;
      code_d    = '0;
      cnt_d     = '0;
      timeout_d = 1'b1;
    end
    if (key_valid || expire || (state_q == S_EMPTY) || (state_q == S_SUBMIT)) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_EMPTY;
      code_q       <= '0;
      cnt_q        <= '0;
      code_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      code_q       <= code_d;
      cnt_q        <= cnt_d;
      code_valid_q <= code_valid_d;
      err_q        <= err_d;
    end
  end

`ifdef DIGIT_ENTRY_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign code       = code_q;
  assign digit_cnt  = cnt_q;
  assign code_valid = code_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_digit_entry.sv
// Directed bench for digit_entry: entry, clear, enter, rejects, reset and (if compiled) timeout.
module tb_digit_entry;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [11:0] code;
  logic        code_valid;
  logic [1:0]  digit_cnt;
  logic        err;
  logic        timeout;

  int unsigned n_cmp;
  int unsigned n_bad;

  digit_entry #(.TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .code       (code),
    .code_valid (code_valid),
    .digit_cnt  (digit_cnt),
    .err        (err),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; key is seen by the next posedge, returns at the following negedge.
  task automatic press(input logic [3:0] k);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_all(input string tag, input logic [11:0] c, input logic [1:0] n,
                         input logic cv, input logic e, input logic t);
    chk({tag, ".code"}, {4'h0, code}, {4'h0, c});
    chk({tag, ".cnt"}, {14'h0, digit_cnt}, {14'h0, n});
    chk({tag, ".cv"}, {15'h0, code_valid}, {15'h0, cv});
    chk({tag, ".err"}, {15'h0, err}, {15'h0, e});
    chk({tag, ".to"}, {15'h0, timeout}, {15'h0, t});
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    idle(2);
    chk_all("reset", 12'h000, 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // 1,2,3,enter
    press(4'h1); chk_all("k1", 12'h001, 2'd1, 1'b0, 1'b0, 1'b0);
    press(4'h2); chk_all("k12", 12'h012, 2'd2, 1'b0, 1'b0, 1'b0);
    press(4'h3); chk_all("k123", 12'h123, 2'd3, 1'b0, 1'b0, 1'b0);
    press(4'hB); chk_all("enter123", 12'h123, 2'd3, 1'b1, 1'b0, 1'b0);
    idle(1);     chk_all("post123", 12'h000, 2'd0, 1'b0, 1'b0, 1'b0);

    // 4,5,clear,7,8,9,enter
    press(4'h4); press(4'h5);
    press(4'hA); chk_all("clear45", 12'h000, 2'd0, 1'b0, 1'b0, 1'b0);
    press(4'h7); press(4'h8); press(4'h9);
    press(4'hB); chk_all("enter789", 12'h789, 2'd3, 1'b1, 1'b0, 1'b0);
    idle(1);     chk_all("post789", 12'h000, 2'd0, 1'b0, 1'b0, 1'b0);

    // enter with one digit is rejected
    press(4'h1);
    press(4'hB); chk_all("early_enter", 12'h001, 2'd1, 1'b0, 1'b1, 1'b0);
    idle(1);     chk_all("early_enter_gap", 12'h001, 2'd1, 1'b0, 1'b0, 1'b0);
    press(4'hA);

    // illegal key while empty
    press(4'hF); chk_all("illegal_empty", 12'h000, 2'd0, 1'b0, 1'b1, 1'b0);

    // fourth digit and illegal key while full
    press(4'h1); press(4'h2); press(4'h3);
    press(4'h4); chk_all("digit_full", 12'h123, 2'd3, 1'b0, 1'b1, 1'b0);
    press(4'hE); chk_all("illegal_full", 12'h123, 2'd3, 1'b0, 1'b1, 1'b0);

    // key during SUBMIT dropped with err
    press(4'hB); chk_all("enter_full", 12'h123, 2'd3, 1'b1, 1'b0, 1'b0);
    press(4'h5); chk_all("key_in_submit", 12'h000, 2'd0, 1'b0, 1'b1, 1'b0);
    idle(1);     chk_all("after_submit", 12'h000, 2'd0, 1'b0, 1'b0, 1'b0);

    // clear while full
    press(4'h1); press(4'h2); press(4'h3);
    press(4'hA); chk_all("clear_full", 12'h000, 2'd0, 1'b0, 1'b0, 1'b0);

    // reset mid-entry overrides a simultaneous key
    press(4'h6);
    press(4'h5); chk_all("k65", 12'h065, 2'd2, 1'b0, 1'b0, 1'b0);
    rst_n     = 1'b0;
    key_valid = 1'b1;
    key_code  = 4'h7;
    @(negedge clk);
    key_valid = 1'b0;
    chk_all("mid_reset", 12'h000, 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    press(4'h0); press(4'h0); press(4'h7);
    press(4'hB); chk_all("enter007", 12'h007, 2'd3, 1'b1, 1'b0, 1'b0);
    idle(1);

    // reset during SUBMIT: no further code_valid
    press(4'h3); press(4'h2); press(4'h1);
    press(4'hB); chk("sub_before_rst.cv", {15'h0, code_valid}, 16'h1);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    chk_all("rst_in_submit", 12'h000, 2'd0, 1'b0, 1'b0, 1'b0);
    idle(1);     chk_all("rst_in_submit2", 12'h000, 2'd0, 1'b0, 1'b0, 1'b0);

`ifdef DIGIT_ENTRY_TIMEOUT_EN
    press(4'h9);
    idle(7);     chk_all("to_idle7", 12'h009, 2'd1, 1'b0, 1'b0, 1'b0);
    idle(1);     chk_all("to_expire", 12'h000, 2'd0, 1'b0, 1'b0, 1'b1);
    idle(1);     chk_all("to_after", 12'h000, 2'd0, 1'b0, 1'b0, 1'b0);
    press(4'h9);
    idle(7);
    press(4'h8); chk_all("to_cancel", 12'h098, 2'd2, 1'b0, 1'b0, 1'b0);
    idle(7);     chk_all("to_restart7", 12'h098, 2'd2, 1'b0, 1'b0, 1'b0);
    idle(1);     chk_all("to_expire2", 12'h000, 2'd0, 1'b0, 1'b0, 1'b1);
`else
    press(4'h9);
    idle(1000);  chk_all("no_timeout", 12'h009, 2'd1, 1'b0, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
